// File: rtl/exception_ctrl_pkg.sv
// Shared definitions for the trap sequencer: cause codes, FSM states and default parameters.
package exception_ctrl_pkg;

   localparam int unsigned XLEN_DEF         = 32;
   localparam int unsigned FLUSH_CYCLES_DEF = 3;
   localparam logic [31:0] EXC_VECTOR_DEF   = 32'h0000_2000;
   localparam int unsigned CNT_W            = 4;

   // Cause value doubles as the rm write strobe, so NONE must stay zero
   typedef enum logic [2:0] {
      CAUSE_NONE    = 3'd0,
      CAUSE_ITLB    = 3'd1,
      CAUSE_ILLEGAL = 3'd2,
      CAUSE_DTLB    = 3'd3,
      CAUSE_IRQ     = 3'd4
   } cause_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_FLUSH,
      ST_REDIRECT
   } state_e;

endpackage

// File: rtl/exception_ctrl_prio_enc.sv
// Combinational priority select of the winning trap source and its rm0/rm1 payload.
module exc_prio_enc
   import exception_ctrl_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEF
) (
   input  logic            m_exc,
   input  logic            d_exc,
   input  logic            f_exc,
   input  logic            irq_take,
   input  logic [XLEN-1:0] f_pc,
   input  logic [XLEN-1:0] d_pc,
   input  logic [XLEN-1:0] m_pc,
   input  logic [XLEN-1:0] m_addr,
   output cause_e          cause_c,
   output logic [XLEN-1:0] rm0_c,
   output logic [XLEN-1:0] rm1_c
);

   // Oldest pipeline stage wins; an IRQ returns to the not-yet-executed decode PC
   always_comb begin
      cause_c = CAUSE_NONE;
      rm0_c   = '0;
      rm1_c   = '0;
      if (m_exc) begin
         cause_c = CAUSE_DTLB;
         rm0_c   = m_pc;
         rm1_c   = m_addr;
      end else if (d_exc) begin
         cause_c = CAUSE_ILLEGAL;
         rm0_c   = d_pc;
      end else if (f_exc) begin
         cause_c = CAUSE_ITLB;
         rm0_c   = f_pc;
         rm1_c   = f_pc;
      end else if (irq_take) begin
         cause_c = CAUSE_IRQ;
         rm0_c   = d_pc;
      end
   end

endmodule

// File: rtl/exception_ctrl.sv
// Trap sequencer: captures the winning exception into rm0..rm2, flushes the pipe,
// then redirects fetch to the trap vector or, for iret, to the saved return PC.
module exception_ctrl
   import exception_ctrl_pkg::*;
#(
   parameter int unsigned     XLEN         = XLEN_DEF,
   parameter int unsigned     FLUSH_CYCLES = FLUSH_CYCLES_DEF,
   parameter logic [XLEN-1:0] EXC_VECTOR   = XLEN'(EXC_VECTOR_DEF)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            f_exc,
   input  logic [XLEN-1:0] f_pc,
   input  logic            d_exc,
   input  logic [XLEN-1:0] d_pc,
   input  logic            m_exc,
   input  logic [XLEN-1:0] m_pc,
   input  logic [XLEN-1:0] m_addr,
   input  logic            irq,
   input  logic            psw_super,
   input  logic            iret_valid,
   input  logic [XLEN-1:0] in_rm0,
   output logic [XLEN-1:0] out_rm0,
   output logic [XLEN-1:0] out_rm1,
   output logic [XLEN-1:0] out_rm2,
   output logic            flush,
   output logic            redir_valid,
   output logic [XLEN-1:0] redir_pc,
   input  logic            redir_ready,
   output logic            psw_set_super,
   output logic            psw_set_user,
   output logic            busy
);

   state_e           state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic             ret, ret_d;
   logic             irq_pend, irq_pend_d;
   logic             irq_take;
   cause_e           sel_cause;
   logic [XLEN-1:0]  sel_rm0, sel_rm1;
   logic [XLEN-1:0]  rm0_d, rm1_d, rm2_d, redir_pc_d;
   logic             flush_d, redir_valid_d, set_super_d;

   assign irq_take = irq_pend & ~psw_super;

   exc_prio_enc #(.XLEN(XLEN)) u_prio (
      .m_exc    (m_exc),
      .d_exc    (d_exc),
      .f_exc    (f_exc),
      .irq_take (irq_take),
      .f_pc     (f_pc),
      .d_pc     (d_pc),
      .m_pc     (m_pc),
      .m_addr   (m_addr),
      .cause_c  (sel_cause),
      .rm0_c    (sel_rm0),
      .rm1_c    (sel_rm1)
   );

   assign busy         = (state != ST_IDLE);
   assign psw_set_user = (state == ST_REDIRECT) & ret & redir_ready;

   // Next state and next registered outputs
   always_comb begin
      state_d       = state;
      cnt_d         = cnt;
      ret_d         = ret;
      irq_pend_d    = irq_pend | irq;
      rm0_d         = '0;
      rm1_d         = '0;
      rm2_d         = '0;
      set_super_d   = 1'b0;
      redir_valid_d = redir_valid;
      redir_pc_d    = redir_pc;
      case (state)
         ST_IDLE: begin
            if (sel_cause != CAUSE_NONE) begin
               state_d     = ST_CAPTURE;
               ret_d       = 1'b0;
               rm0_d       = sel_rm0;
               rm1_d       = sel_rm1;
               rm2_d       = XLEN'(sel_cause);
               set_super_d = 1'b1;
               // A fresh irq level in the taking cycle re-arms the pending flag
               if (sel_cause == CAUSE_IRQ) irq_pend_d = irq;
            end else if (iret_valid) begin
               state_d = ST_FLUSH;
               ret_d   = 1'b1;
               cnt_d   = CNT_W'(FLUSH_CYCLES);
            end
         end
         ST_CAPTURE: begin
            state_d = ST_FLUSH;
            cnt_d   = CNT_W'(FLUSH_CYCLES);
         end
         ST_FLUSH: begin
            if (cnt == CNT_W'(1)) begin
               state_d       = ST_REDIRECT;
               redir_valid_d = 1'b1;
               redir_pc_d    = ret ? in_rm0 : EXC_VECTOR;
            end else begin
               cnt_d = cnt - CNT_W'(1);
            end
         end
         ST_REDIRECT: begin
            if (redir_ready) begin
               state_d       = ST_IDLE;
               ret_d         = 1'b0;
               redir_valid_d = 1'b0;
               redir_pc_d    = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      flush_d = (state_d == ST_FLUSH);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= ST_IDLE;
         cnt           <= '0;
         ret           <= 1'b0;
         irq_pend      <= 1'b0;
         out_rm0       <= '0;
         out_rm1       <= '0;
         out_rm2       <= '0;
         psw_set_super <= 1'b0;
         flush         <= 1'b0;
         redir_valid   <= 1'b0;
         redir_pc      <= '0;
      end else begin
         state         <= state_d;
         cnt           <= cnt_d;
         ret           <= ret_d;
         irq_pend      <= irq_pend_d;
         out_rm0       <= rm0_d;
         out_rm1       <= rm1_d;
         out_rm2       <= rm2_d;
         psw_set_super <= set_super_d;
         flush         <= flush_d;
         redir_valid   <= redir_valid_d;
         redir_pc      <= redir_pc_d;
      end
   end

endmodule
